dcache_mshr: RTL and testbench



---
 rtl/sys_defs.sv | 33 +++
 rtl/mshr_free_picker.sv | 23 ++
 rtl/dcache_mshr.sv | 186 ++++++++++++++++++
 tb/tb_dcache_mshr.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared cache/memory definitions: block geometry macros, bus commands and the
// MSHR entry layout used by the data cache miss path and the LSQ.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`define BLOCK_OFFSET 3
`define INDEX_SIZE   5
`define TAG_SIZE     (64 - `INDEX_SIZE - `BLOCK_OFFSET)

package sys_defs;

    localparam int BLOCK_OFF  = `BLOCK_OFFSET;
    localparam int IDX_W      = `INDEX_SIZE;
    localparam int TAG_W      = `TAG_SIZE;
    localparam int MSHR_LSQ_W = 3;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef struct packed {
        logic                  valid;
        logic [3:0]            mem_tag;
        logic [TAG_W-1:0]      tag;
        logic [IDX_W-1:0]      index;
        logic [MSHR_LSQ_W-1:0] lsq_id;
    } MSHR_ENTRY;

endpackage

`endif

// File: rtl/mshr_free_picker.sv
// Priority encoder: lowest-numbered free slot plus an any-free flag.
module mshr_free_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     busy,
    output logic [IDX_W-1:0] free_idx,
    output logic             any_free
);

    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        // Scan downward so the lowest free slot wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_mshr.sv
// Data-cache miss-status holding registers: tracks outstanding load misses by
// memory tag and issues fill + LSQ completion. Optional counters: DCACHE_MSHR_STATS_EN.
module dcache_mshr
    import sys_defs::*;
#(
    parameter int MSHR_DEPTH = 4,
    parameter int LSQ_IDX_W  = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   alloc_req,
    input  logic [63:0]            alloc_addr,
    input  logic [LSQ_IDX_W-1:0]   alloc_lsq_id,
    input  logic [3:0]             Dmem2proc_response,
    input  logic [3:0]             Dmem2proc_tag,
    input  logic [63:0]            Dmem2proc_data,
    output logic                   mshr_full,
    output logic                   alloc_retry,
    output logic                   fill_valid,
    output logic [`INDEX_SIZE-1:0] fill_index,
    output logic [`TAG_SIZE-1:0]   fill_tag,
    output logic [63:0]            fill_data,
    output logic                   ld_done_valid,
    output logic [LSQ_IDX_W-1:0]   ld_done_lsq_id,
    output logic [63:0]            ld_done_data,
    output logic                   mshr_err
`ifdef DCACHE_MSHR_STATS_EN
    ,
    output logic [31:0]            stat_allocs,
    output logic [31:0]            stat_retries,
    output logic [31:0]            stat_full_cycles
`endif
);

    localparam int SLOT_W = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;

    MSHR_ENTRY entries_q [MSHR_DEPTH];
    MSHR_ENTRY entries_d [MSHR_DEPTH];

    logic [MSHR_DEPTH-1:0] busy, hit_vec, dup_vec;
    logic [SLOT_W-1:0]     free_idx, hit_idx;
    logic                  any_free, any_hit, multi_hit, alloc_fire;
    logic [3:0]            hit_cnt, valid_cnt;
    logic                  mshr_full_q, mshr_full_d;
    logic                  mshr_err_q, mshr_err_d;
    logic                  fill_valid_q, fill_valid_d;
    logic [IDX_W-1:0]      fill_index_q, fill_index_d;
    logic [TAG_W-1:0]      fill_tag_q, fill_tag_d;
    logic [63:0]           fill_data_q, fill_data_d;
    logic [LSQ_IDX_W-1:0]  ld_lsq_q, ld_lsq_d;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^alloc_addr[`BLOCK_OFFSET-1:0];

    mshr_free_picker #(.N(MSHR_DEPTH), .IDX_W(SLOT_W)) u_free_picker (
        .busy     (busy),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    always_comb begin
        busy    = '0;
        hit_vec = '0;
        dup_vec = '0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            busy[i]    = entries_q[i].valid;
            hit_vec[i] = entries_q[i].valid && (Dmem2proc_tag != 4'd0) &&
                         (entries_q[i].mem_tag == Dmem2proc_tag);
            dup_vec[i] = entries_q[i].valid &&
                         (entries_q[i].mem_tag == Dmem2proc_response);
        end
    end

    // Completion matches only entries valid before this edge; lowest index wins.
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        hit_cnt = '0;
        for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_idx = SLOT_W'(i);
                any_hit = 1'b1;
                hit_cnt = hit_cnt + 4'd1;
            end
        end
        multi_hit = (hit_cnt > 4'd1);
    end

    assign alloc_retry = alloc_req && (mshr_full_q || (Dmem2proc_response == 4'd0));
    assign alloc_fire  = alloc_req && (Dmem2proc_response != 4'd0) && !mshr_full_q && any_free;

    always_comb begin
        entries_d = entries_q;
        if (any_hit) begin
            entries_d[hit_idx].valid = 1'b0;
        end
        if (alloc_fire) begin
            entries_d[free_idx].valid   = 1'b1;
            entries_d[free_idx].mem_tag = Dmem2proc_response;
            {entries_d[free_idx].tag, entries_d[free_idx].index} = alloc_addr[63:`BLOCK_OFFSET];
            entries_d[free_idx].lsq_id  = MSHR_LSQ_W'(alloc_lsq_id);
        end

        valid_cnt = '0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            valid_cnt = valid_cnt + {3'b000, entries_d[i].valid};
        end
        mshr_full_d = (valid_cnt == 4'(MSHR_DEPTH));

        mshr_err_d = mshr_err_q
                   | ((Dmem2proc_tag != 4'd0) && !any_hit)
                   | multi_hit
                   | (alloc_fire && (|dup_vec));

        fill_valid_d = any_hit;
        fill_index_d = any_hit ? entries_q[hit_idx].index : '0;
        fill_tag_d   = any_hit ? entries_q[hit_idx].tag : '0;
        fill_data_d  = any_hit ? Dmem2proc_data : '0;
        ld_lsq_d     = any_hit ? LSQ_IDX_W'(entries_q[hit_idx].lsq_id) : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            mshr_full_q  <= 1'b0;
            mshr_err_q   <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_index_q <= '0;
            fill_tag_q   <= '0;
            fill_data_q  <= '0;
            ld_lsq_q     <= '0;
        end else begin
            entries_q    <= entries_d;
            mshr_full_q  <= mshr_full_d;
            mshr_err_q   <= mshr_err_d;
            fill_valid_q <= fill_valid_d;
            fill_index_q <= fill_index_d;
            fill_tag_q   <= fill_tag_d;
            fill_data_q  <= fill_data_d;
            ld_lsq_q     <= ld_lsq_d;
        end
    end

    assign mshr_full      = mshr_full_q;
    assign mshr_err       = mshr_err_q;
    assign fill_valid     = fill_valid_q;
    assign fill_index     = fill_index_q;
    assign fill_tag       = fill_tag_q;
    assign fill_data      = fill_data_q;
    assign ld_done_valid  = fill_valid_q;
    assign ld_done_lsq_id = ld_lsq_q;
    assign ld_done_data   = fill_data_q;

`ifdef DCACHE_MSHR_STATS_EN
    logic [31:0] allocs_q, allocs_d, retries_q, retries_d, full_cyc_q, full_cyc_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        allocs_d   = sat_inc(allocs_q, alloc_fire);
        retries_d  = sat_inc(retries_q, alloc_retry);
        full_cyc_d = sat_inc(full_cyc_q, mshr_full_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            allocs_q   <= '0;
            retries_q  <= '0;
            full_cyc_q <= '0;
        end else begin
            allocs_q   <= allocs_d;
            retries_q  <= retries_d;
            full_cyc_q <= full_cyc_d;
        end
    end

    assign stat_allocs      = allocs_q;
    assign stat_retries     = retries_q;
    assign stat_full_cycles = full_cyc_q;
`endif

endmodule

// File: tb/tb_dcache_mshr.sv
// Randomized scoreboard bench for dcache_mshr against a slot-array reference model.
module tb_dcache_mshr;
    import sys_defs::*;

    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              alloc_req = 1'b0;
    logic [63:0]       alloc_addr = '0;
    logic [LW-1:0]     alloc_lsq_id = '0;
    logic [3:0]        Dmem2proc_response = '0;
    logic [3:0]        Dmem2proc_tag = '0;
    logic [63:0]       Dmem2proc_data = '0;
    logic              mshr_full, alloc_retry, fill_valid, ld_done_valid, mshr_err;
    logic [IDX_W-1:0]  fill_index;
    logic [TAG_W-1:0]  fill_tag;
    logic [63:0]       fill_data, ld_done_data;
    logic [LW-1:0]     ld_done_lsq_id;
`ifdef DCACHE_MSHR_STATS_EN
    logic [31:0]       stat_allocs, stat_retries, stat_full_cycles;
`endif

    dcache_mshr #(.MSHR_DEPTH(DEPTH), .LSQ_IDX_W(LW)) dut (
        .clock              (clock),
        .reset              (reset),
        .alloc_req          (alloc_req),
        .alloc_addr         (alloc_addr),
        .alloc_lsq_id       (alloc_lsq_id),
        .Dmem2proc_response (Dmem2proc_response),
        .Dmem2proc_tag      (Dmem2proc_tag),
        .Dmem2proc_data     (Dmem2proc_data),
        .mshr_full          (mshr_full),
        .alloc_retry        (alloc_retry),
        .fill_valid         (fill_valid),
        .fill_index         (fill_index),
        .fill_tag           (fill_tag),
        .fill_data          (fill_data),
        .ld_done_valid      (ld_done_valid),
        .ld_done_lsq_id     (ld_done_lsq_id),
        .ld_done_data       (ld_done_data),
        .mshr_err           (mshr_err)
`ifdef DCACHE_MSHR_STATS_EN
        ,
        .stat_allocs        (stat_allocs),
        .stat_retries       (stat_retries),
        .stat_full_cycles   (stat_full_cycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tg;
        logic [LW-1:0]    lsq;
        logic [63:0]      data;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: one record per slot, filled lowest-free-first.
    bit          m_valid [DEPTH];
    logic [3:0]  m_mtag  [DEPTH];
    logic [63:0] m_addr  [DEPTH];
    logic [LW-1:0] m_lsq [DEPTH];
    bit          m_err;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_full();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_valid[i] ? 1 : 0;
        return n == DEPTH;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_err = 1'b0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit areq, input logic [63:0] addr, input logic [LW-1:0] lsq,
                        input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] data);
        int   hit, nmatch, slot;
        bit   full, fire;
        exp_t e;
        alloc_req          = areq;
        alloc_addr         = addr;
        alloc_lsq_id       = lsq;
        Dmem2proc_response = resp;
        Dmem2proc_tag      = tag;
        Dmem2proc_data     = data;
        full = model_full();
        #1;
        chk("alloc_retry", alloc_retry, areq && (full || resp == 4'd0));

        hit = -1;
        nmatch = 0;
        if (tag != 4'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_valid[i] && m_mtag[i] == tag) begin
                    nmatch++;
                    if (hit < 0) hit = i;
                end
            end
            if (hit < 0) m_err = 1'b1;
            if (nmatch > 1) m_err = 1'b1;
        end
        if (hit >= 0) begin
            e.idx  = IDX_W'((m_addr[hit] >> BLOCK_OFF) % (64'd1 << IDX_W));
            e.tg   = TAG_W'(m_addr[hit] >> (BLOCK_OFF + IDX_W));
            e.lsq  = m_lsq[hit];
            e.data = data;
            exp_q.push_back(e);
        end

        fire = areq && resp != 4'd0 && !full;
        slot = -1;
        if (fire) begin
            for (int i = 0; i < DEPTH; i++)
                if (m_valid[i] && m_mtag[i] == resp) m_err = 1'b1;
            for (int i = DEPTH - 1; i >= 0; i--)
                if (!m_valid[i]) slot = i;
        end

        @(posedge clock);
        if (hit >= 0) m_valid[hit] = 1'b0;
        if (slot >= 0) begin
            m_valid[slot] = 1'b1;
            m_mtag[slot]  = resp;
            m_addr[slot]  = addr;
            m_lsq[slot]   = lsq;
        end
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, 64'd0, '0, 4'd0, 4'd0, 64'd0);
    endtask

    task automatic do_reset();
        alloc_req = 1'b0;
        Dmem2proc_response = '0;
        Dmem2proc_tag = '0;
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_fill_valid", fill_valid, 1'b0);
        chk("rst_ld_done_valid", ld_done_valid, 1'b0);
        chk("rst_mshr_full", mshr_full, 1'b0);
        chk("rst_mshr_err", mshr_err, 1'b0);
        chk("rst_ld_done_data", ld_done_data, 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Monitor: every cycle, compare outputs against whatever the scoreboard expects.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fill_valid", fill_valid, 1'b1);
                chk("ld_done_valid", ld_done_valid, 1'b1);
                chk("fill_index", fill_index, e.idx);
                chk("fill_tag", fill_tag, e.tg);
                chk("fill_data", fill_data, e.data);
                chk("ld_done_lsq_id", ld_done_lsq_id, e.lsq);
                chk("ld_done_data", ld_done_data, e.data);
            end else begin
                chk("fill_valid_idle", fill_valid, 1'b0);
                chk("ld_done_valid_idle", ld_done_valid, 1'b0);
            end
            chk("mshr_full", mshr_full, model_full());
            chk("mshr_err", mshr_err, m_err);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] tags[$];
        int         r;
        logic [3:0] t;
        model_clear();
        #1 reset = 1'b0;
        @(negedge clock);
        chk("init_fill_valid", fill_valid, 1'b0);
        chk("init_mshr_full", mshr_full, 1'b0);
        chk("init_mshr_err", mshr_err, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // Single miss and its return.
        step(1'b1, 64'h1008, 3'd2, 4'd5, 4'd0, 64'd0);
        step(1'b0, 64'd0, '0, 4'd0, 4'd5, 64'hDEAD);
        idle();

        // Fill all slots, retry when full, free one.
        for (int i = 1; i <= 4; i++)
            step(1'b1, {$urandom, $urandom}, LW'(i - 1), 4'(i), 4'd0, 64'd0);
        step(1'b1, 64'h2000, 3'd4, 4'd6, 4'd0, 64'd0);
        step(1'b0, 64'd0, '0, 4'd0, 4'd3, 64'h3333);
        idle();
        step(1'b0, 64'd0, '0, 4'd0, 4'd1, 64'h1111);
        step(1'b0, 64'd0, '0, 4'd0, 4'd2, 64'h2222);
        step(1'b0, 64'd0, '0, 4'd0, 4'd4, 64'h4444);

        // Memory rejects the request.
        step(1'b1, 64'h3000, 3'd1, 4'd0, 4'd0, 64'd0);

        // Out-of-order returns.
        for (int i = 1; i <= 3; i++)
            step(1'b1, 64'h4000 + 64'(i * 8), LW'(i - 1), 4'(i), 4'd0, 64'd0);
        step(1'b0, 64'd0, '0, 4'd0, 4'd3, 64'hA3);
        step(1'b0, 64'd0, '0, 4'd0, 4'd1, 64'hA1);
        step(1'b0, 64'd0, '0, 4'd0, 4'd2, 64'hA2);

        // Allocate and complete in the same cycle.
        step(1'b1, 64'h5008, 3'd3, 4'd4, 4'd0, 64'd0);
        step(1'b1, 64'h6010, 3'd5, 4'd7, 4'd4, 64'hB4);
        step(1'b0, 64'd0, '0, 4'd0, 4'd7, 64'hB7);

        // Orphan completion.
        step(1'b0, 64'd0, '0, 4'd0, 4'd9, 64'h99);
        idle();
        idle();

        // Reset with entries outstanding, then a stale return.
        step(1'b1, 64'h7000, 3'd0, 4'd1, 4'd0, 64'd0);
        step(1'b1, 64'h7008, 3'd1, 4'd2, 4'd0, 64'd0);
        do_reset();
        idle();
        step(1'b0, 64'd0, '0, 4'd0, 4'd1, 64'h77);
        do_reset();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            tags.delete();
            for (int i = 0; i < DEPTH; i++) if (m_valid[i]) tags.push_back(m_mtag[i]);
            r = $urandom_range(0, 99);
            if (r < 65 && tags.size() > 0) t = tags[$urandom_range(0, tags.size() - 1)];
            else if (r < 92) t = 4'd0;
            else t = 4'($urandom_range(1, 15));
            step(($urandom_range(0, 99) < 60),
                 {$urandom, $urandom},
                 LW'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < 15) ? 4'd0 : 4'($urandom_range(1, 15)),
                 t,
                 {$urandom, $urandom});
        end

        idle();
        idle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
